// File: rtl/ram_clr_bank.sv
// Single-port synchronous RAM with byte-enable writes, optional registered read,
// and a clear engine that zeroes a fixed address window one word per clock.
module ram_clr_bank #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int CLR_BASE  = 0,
    parameter int CLR_COUNT = 32,
    parameter int RD_REG    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                busy,
    output logic                done,
    output logic                wr_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(CLR_BASE);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_BASE + CLR_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              start_acc;
    logic              clr_we;
    logic              in_range;
    logic              wr_open;
    logic              user_we;
    logic              wr_drop;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  ptr_idx;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        start_acc  = 1'b0;
        clr_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = S_CLEAR;
                    ptr_next   = CLR_FIRST;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (ptr == CLR_LAST) begin
                    state_next = S_DONE;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_CLEAR);
    assign done = (state == S_DONE);

    // A start accepted from IDLE owns the edge, so a simultaneous write is dropped.
    assign in_range = ({1'b0, adr} < DEPTH_L);
    assign wr_open  = (state != S_CLEAR) && !start_acc;
    assign user_we  = we && wr_open && in_range;
    assign wr_drop  = we && !(wr_open && in_range);

    assign idx     = adr[IDX_W-1:0];
    assign ptr_idx = ptr[IDX_W-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= CLR_FIRST;
            wr_err <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            wr_err <= wr_drop;
        end
    end

    // NOTE: the storage array deliberately has no reset; a reset mid-sweep must
    // leave both cleared and uncleared words exactly as they were.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_idx] <= '0;
        end else if (user_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = in_range ? mem[idx] : '0;

    generate
        if (RD_REG != 0) begin : g_rd_reg
            // Read-first: the array is sampled before any same-edge write lands.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout <= '0;
                end else begin
                    dout <= rd_data;
                end
            end
        end else begin : g_rd_comb
            assign dout = rd_data;
        end
    endgenerate

endmodule
